// File: rtl/isa_pkg.sv
// Shared ISA constants: opcode encodings, datapath widths and the fetch sequencer state encoding.
package isa_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 8;

    // Opcode space spans 8'd3 .. 8'd40; only END and JUMNZ are interpreted by fetch.
    localparam logic [7:0] OP_EN0   = 8'd3;
    localparam logic [7:0] OP_END   = 8'd38;
    localparam logic [7:0] OP_JUMNZ = 8'd40;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_JUMP   = 3'd2,
        ST_REFILL = 3'd3,
        ST_HALT   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Per-core fetch sequencer: owns the PC, drives the instruction memory address,
// issues opcodes to the decoder, resolves JUMNZ internally and halts on END.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = isa_pkg::ADDR_W,
    parameter int unsigned          INSTR_W  = isa_pkg::INSTR_W,
    parameter int unsigned          RESET_PC = 0,
    parameter logic [INSTR_W-1:0]   OP_END   = INSTR_W'(isa_pkg::OP_END),
    parameter logic [INSTR_W-1:0]   OP_JUMNZ = INSTR_W'(isa_pkg::OP_JUMNZ)
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  addr,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    input  logic               acc_zero,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               halted
);

    isa_pkg::fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
    logic [INSTR_W-1:0]    instr_out_q, instr_out_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  halted_q, halted_d;
    logic [ADDR_W-1:0]     pc_inc;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Re-present the current word while stalled or halted; otherwise fetch ahead.
    always_comb begin
        if ((state_q == isa_pkg::ST_RUN && stall) || state_q == isa_pkg::ST_HALT) begin
            addr = cur_addr_q;
        end else begin
            addr = pc_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cur_addr_d    = cur_addr_q;
        instr_out_d   = instr_out_q;
        instr_valid_d = 1'b0;
        halted_d      = halted_q;

        case (state_q)
            isa_pkg::ST_BOOT: begin
                cur_addr_d = pc_q;
                pc_d       = pc_inc;
                state_d    = isa_pkg::ST_RUN;
            end
            isa_pkg::ST_RUN: begin
                if (!stall) begin
                    if (instruction == OP_JUMNZ) begin
                        cur_addr_d = pc_q;
                        pc_d       = pc_inc;
                        state_d    = isa_pkg::ST_JUMP;
                    end else begin
                        instr_out_d   = instruction;
                        instr_valid_d = 1'b1;
                        if (instruction == OP_END) begin
                            halted_d = 1'b1;
                            state_d  = isa_pkg::ST_HALT;
                        end else begin
                            cur_addr_d = pc_q;
                            pc_d       = pc_inc;
                        end
                    end
                end
            end
            // Operand word is on the bus; the speculative fetch at pc is discarded.
            isa_pkg::ST_JUMP: begin
                if (!acc_zero) begin
                    pc_d = ADDR_W'(instruction);
                end else begin
                    pc_d = cur_addr_q + ADDR_W'(1);
                end
                state_d = isa_pkg::ST_REFILL;
            end
            isa_pkg::ST_REFILL: begin
                cur_addr_d = pc_q;
                pc_d       = pc_inc;
                state_d    = isa_pkg::ST_RUN;
            end
            isa_pkg::ST_HALT: begin
                state_d = isa_pkg::ST_HALT;
            end
            default: begin
                state_d = isa_pkg::ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= isa_pkg::ST_BOOT;
            pc_q          <= ADDR_W'(RESET_PC);
            cur_addr_q    <= ADDR_W'(RESET_PC);
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cur_addr_q    <= cur_addr_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule
